// File: rtl/rv_pkg.sv
// Shared RV32 write-back types: data/address widths, write-back source
// selector and the {rd, wd} request payload.
package rv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREGS  = 32;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_MD   = 2'd2
    } wb_src_e;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   wd;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back requests; push is ignored when full and
// pop when empty, so the caller may assert both freely.
module wb_fifo
    import rv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  wb_req_t                i_data,
    input  logic                   i_pop,
    output wb_req_t                o_head_c,
    output logic                   o_full_c,
    output logic                   o_empty_c,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    wb_req_t       r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full_c  = (r_count == CW'(DEPTH));
    assign o_empty_c = (r_count == '0);
    assign o_head_c  = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    assign w_push = i_push && !o_full_c;
    assign w_pop  = i_pop && !o_empty_c;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: ALU results win, mul/div results queue in
// wb_fifo. Pending-write scoreboard is built only with RF_WB_SCOREBOARD_EN.
module regfile_wb_arbiter
    import rv_pkg::*;
#(
    parameter int unsigned MD_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alu_valid,
    input  logic [REG_AW-1:0]         alu_rd,
    input  logic [XLEN-1:0]           alu_wd,
    input  logic                      md_valid,
    output logic                      md_ready,
    input  logic [REG_AW-1:0]         md_rd,
    input  logic [XLEN-1:0]           md_wd,
    input  logic                      issue_valid,
    input  logic [REG_AW-1:0]         issue_rd,
    input  logic [REG_AW-1:0]         rs1,
    input  logic [REG_AW-1:0]         rs2,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    output logic                      reg_write,
    output logic [REG_AW-1:0]         rd,
    output logic [XLEN-1:0]           wd,
    output logic [$clog2(MD_DEPTH):0] md_count
);

    localparam int unsigned CW = $clog2(MD_DEPTH) + 1;

    wb_src_e           w_src;
    wb_req_t           w_sel;
    wb_req_t           w_head;
    wb_req_t           w_md_req;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [CW-1:0]     w_count;
    logic              r_reg_write;
    logic [REG_AW-1:0] r_rd;
    logic [XLEN-1:0]   r_wd;

    assign md_ready = !w_full;
    assign w_push   = md_valid && !w_full;
    assign w_md_req = '{rd: md_rd, wd: md_wd};

    // Fixed priority: ALU first, then the oldest buffered mul/div result.
    always_comb begin
        w_src = WB_NONE;
        w_sel = '0;
        if (alu_valid) begin
            w_src = WB_ALU;
            w_sel = '{rd: alu_rd, wd: alu_wd};
        end else if (!w_empty) begin
            w_src = WB_MD;
            w_sel = w_head;
        end
    end

    assign w_pop = (w_src == WB_MD);

    wb_fifo #(
        .DEPTH (MD_DEPTH)
    ) u_md_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_data    (w_md_req),
        .i_pop     (w_pop),
        .o_head_c  (w_head),
        .o_full_c  (w_full),
        .o_empty_c (w_empty),
        .o_count   (w_count)
    );

    // x0 writes are consumed from their source but never reach the file.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg_write <= 1'b0;
            r_rd        <= '0;
            r_wd        <= '0;
        end else begin
            r_reg_write <= (w_src != WB_NONE) && (w_sel.rd != '0);
            r_rd        <= w_sel.rd;
            r_wd        <= w_sel.wd;
        end
    end

    assign reg_write = r_reg_write;
    assign rd        = r_rd;
    assign wd        = r_wd;
    assign md_count  = w_count;

`ifdef RF_WB_SCOREBOARD_EN
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    // Clear on head selection, then set, so a same-cycle issue wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop)       w_busy_nxt[w_head.rd] = 1'b0;
        if (issue_valid) w_busy_nxt[issue_rd]  = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) r_busy <= '0;
        else     r_busy <= w_busy_nxt;
    end

    assign rs1_busy = r_busy[rs1];
    assign rs2_busy = r_busy[rs2];
`else
    logic w_unused_sb;
    assign w_unused_sb = ^{issue_valid, issue_rd, rs1, rs2};
    assign rs1_busy    = 1'b0;
    assign rs2_busy    = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// against a queue-based model; follows RF_WB_SCOREBOARD_EN like the design.
module tb_regfile_wb_arbiter;
    import rv_pkg::*;

    localparam int unsigned DEPTH = 2;
`ifdef RF_WB_SCOREBOARD_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, md_valid, md_ready, issue_valid;
    logic [4:0]  alu_rd, md_rd, issue_rd, rs1, rs2, rd;
    logic [31:0] alu_wd, md_wd, wd;
    logic        rs1_busy, rs2_busy, reg_write;
    logic [1:0]  md_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: FIFO contents, busy set, expected registered write.
    wb_req_t     mq[$];
    logic [31:0] mbusy = '0;
    logic        e_rw  = 1'b0;
    logic [4:0]  e_rd  = '0;
    logic [31:0] e_wd  = '0;

    regfile_wb_arbiter #(.MD_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd),
        .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_wd(md_wd),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .reg_write(reg_write), .rd(rd), .wd(wd), .md_count(md_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        wb_req_t h;
        logic    push;
        if (rst) begin
            mq.delete();
            mbusy = '0;
            e_rw  = 1'b0;
            e_rd  = '0;
            e_wd  = '0;
        end else begin
            push = md_valid && (mq.size() < int'(DEPTH));
            if (alu_valid) begin
                e_rw = (alu_rd != 0); e_rd = alu_rd; e_wd = alu_wd;
            end else if (mq.size() > 0) begin
                h = mq.pop_front();
                e_rw = (h.rd != 0); e_rd = h.rd; e_wd = h.wd;
                if (SB) mbusy[h.rd] = 1'b0;
            end else begin
                e_rw = 1'b0; e_rd = '0; e_wd = '0;
            end
            if (SB && issue_valid) mbusy[issue_rd] = 1'b1;
            mbusy[0] = 1'b0;
            if (push) mq.push_back('{rd: md_rd, wd: md_wd});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; alu_rd = 0; alu_wd = 0;
        md_valid = 0; md_rd = 0; md_wd = 0;
        issue_valid = 0; issue_rd = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle(); alu_valid = 1; alu_rd = 7; alu_wd = 32'h1234; md_valid = 1;
        rs1 = 5; rs2 = 6;
        tick();
        n_checks++; if (reg_write !== 1'b0) $display("FAIL rst_reg_write: got %0h expected 0", reg_write); else n_pass++;
        n_checks++; if (rd !== 5'd0) $display("FAIL rst_rd: got %0h expected 0", rd); else n_pass++;
        n_checks++; if (wd !== 32'd0) $display("FAIL rst_wd: got %0h expected 0", wd); else n_pass++;
        n_checks++; if (md_count !== 2'd0) $display("FAIL rst_md_count: got %0h expected 0", md_count); else n_pass++;
        n_checks++; if (md_ready !== 1'b1) $display("FAIL rst_md_ready: got %0h expected 1", md_ready); else n_pass++;
        n_checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) $display("FAIL rst_busy: got %0h%0h expected 00", rs1_busy, rs2_busy); else n_pass++;
        rst = 0; idle();
    endtask

    task automatic test_alu();
        idle(); alu_valid = 1; alu_rd = 3; alu_wd = 32'h0000000F;
        tick();
        n_checks++; if (reg_write !== 1'b1 || rd !== 5'd3 || wd !== 32'hF)
            $display("FAIL alu_write: got we=%0h rd=%0d wd=%0h expected we=1 rd=3 wd=f", reg_write, rd, wd); else n_pass++;
        idle();
        tick();
        n_checks++; if (reg_write !== 1'b0) $display("FAIL alu_idle: got %0h expected 0", reg_write); else n_pass++;
    endtask

    task automatic test_contention();
        idle(); alu_valid = 1; alu_rd = 5; alu_wd = 32'h11;
        md_valid = 1; md_rd = 6; md_wd = 32'h3C;
        #1;
        n_checks++; if (md_ready !== 1'b1) $display("FAIL cont_ready: got %0h expected 1", md_ready); else n_pass++;
        tick(); idle();
        n_checks++; if (reg_write !== 1'b1 || rd !== 5'd5 || wd !== 32'h11)
            $display("FAIL cont_alu_first: got we=%0h rd=%0d wd=%0h expected we=1 rd=5 wd=11", reg_write, rd, wd); else n_pass++;
        n_checks++; if (md_count !== 2'd1) $display("FAIL cont_count1: got %0d expected 1", md_count); else n_pass++;
        tick();
        n_checks++; if (reg_write !== 1'b1 || rd !== 5'd6 || wd !== 32'h3C)
            $display("FAIL cont_md_next: got we=%0h rd=%0d wd=%0h expected we=1 rd=6 wd=3c", reg_write, rd, wd); else n_pass++;
        n_checks++; if (md_count !== 2'd0) $display("FAIL cont_count0: got %0d expected 0", md_count); else n_pass++;
    endtask

    task automatic test_scoreboard();
        idle(); rs1 = 5; issue_valid = 1; issue_rd = 5;
        tick(); idle();
        n_checks++; if (rs1_busy !== SB) $display("FAIL sb_set: got %0h expected %0h", rs1_busy, SB); else n_pass++;
        md_valid = 1; md_rd = 5; md_wd = 32'h77;
        tick(); idle();
        n_checks++; if (rs1_busy !== SB) $display("FAIL sb_sel_cycle: got %0h expected %0h", rs1_busy, SB); else n_pass++;
        tick();
        n_checks++; if (rs1_busy !== 1'b0) $display("FAIL sb_clear: got %0h expected 0", rs1_busy); else n_pass++;
        n_checks++; if (reg_write !== 1'b1 || rd !== 5'd5 || wd !== 32'h77)
            $display("FAIL sb_md_write: got we=%0h rd=%0d wd=%0h expected we=1 rd=5 wd=77", reg_write, rd, wd); else n_pass++;
        // Issue to rd 9 in the same cycle its older result is selected.
        rs2 = 9; issue_valid = 1; issue_rd = 9; md_valid = 1; md_rd = 9; md_wd = 32'h99;
        tick(); idle(); issue_valid = 1; issue_rd = 9;
        tick(); idle();
        n_checks++; if (rs2_busy !== SB) $display("FAIL sb_set_wins: got %0h expected %0h", rs2_busy, SB); else n_pass++;
        n_checks++; if (reg_write !== 1'b1 || rd !== 5'd9) $display("FAIL sb_set_wins_write: got we=%0h rd=%0d expected we=1 rd=9", reg_write, rd); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int   exp_rd_t  [7] = '{10, 11, 12, 13, 20, 21, 22};
        int   exp_cnt_t [7] = '{1, 2, 2, 2, 1, 1, 0};
        logic exp_rdy_t [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int   oi = 0;
        logic adv;
        logic [31:0] exp_wd;
        idle();
        for (int c = 0; c < 7; c++) begin
            alu_valid = (c < 4); alu_rd = 5'(10 + c); alu_wd = 32'(100 + c);
            md_valid = (oi < 3); md_rd = 5'(20 + oi); md_wd = 32'(32'hA0 + oi);
            #1;
            n_checks++; if (md_ready !== exp_rdy_t[c]) $display("FAIL b2b_ready[%0d]: got %0h expected %0h", c, md_ready, exp_rdy_t[c]); else n_pass++;
            adv = md_valid && md_ready;
            tick();
            if (adv) oi++;
            exp_wd = (c < 4) ? 32'(100 + c) : 32'(32'hA0 + c - 4);
            n_checks++; if (reg_write !== 1'b1 || rd !== 5'(exp_rd_t[c]) || wd !== exp_wd)
                $display("FAIL b2b_write[%0d]: got we=%0h rd=%0d wd=%0h expected we=1 rd=%0d wd=%0h", c, reg_write, rd, wd, exp_rd_t[c], exp_wd); else n_pass++;
            n_checks++; if (int'(md_count) != exp_cnt_t[c]) $display("FAIL b2b_count[%0d]: got %0d expected %0d", c, md_count, exp_cnt_t[c]); else n_pass++;
        end
        idle();
    endtask

    task automatic test_x0();
        idle(); alu_valid = 1; alu_rd = 0; alu_wd = 32'hFFFFFFFF; issue_valid = 1; issue_rd = 0;
        tick(); idle();
        n_checks++; if (reg_write !== 1'b0) $display("FAIL x0_write: got %0h expected 0", reg_write); else n_pass++;
        for (int r = 0; r < 32; r++) begin
            rs1 = 5'(r); #1;
            n_checks++; if (rs1_busy !== mbusy[r]) $display("FAIL x0_busy[%0d]: got %0h expected %0h", r, rs1_busy, mbusy[r]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        idle(); issue_valid = 1; issue_rd = 7;
        tick(); idle(); issue_valid = 1; issue_rd = 8; alu_valid = 1; alu_rd = 1; md_valid = 1; md_rd = 7; md_wd = 32'h7;
        tick(); idle(); alu_valid = 1; alu_rd = 2; md_valid = 1; md_rd = 8; md_wd = 32'h8;
        tick(); idle(); rs1 = 7;
        #1;
        n_checks++; if (md_count !== 2'd2 || md_ready !== 1'b0) $display("FAIL mid_prefill: got count=%0d ready=%0h expected count=2 ready=0", md_count, md_ready); else n_pass++;
        n_checks++; if (rs1_busy !== SB) $display("FAIL mid_prebusy: got %0h expected %0h", rs1_busy, SB); else n_pass++;
        rst = 1; alu_valid = 1; alu_rd = 4; issue_valid = 1; issue_rd = 4;
        tick();
        n_checks++; if (md_count !== 2'd0 || md_ready !== 1'b1) $display("FAIL mid_flush: got count=%0d ready=%0h expected count=0 ready=1", md_count, md_ready); else n_pass++;
        n_checks++; if (reg_write !== 1'b0) $display("FAIL mid_we: got %0h expected 0", reg_write); else n_pass++;
        for (int r = 0; r < 32; r++) begin
            rs1 = 5'(r); #1;
            n_checks++; if (rs1_busy !== 1'b0) $display("FAIL mid_busy[%0d]: got %0h expected 0", r, rs1_busy); else n_pass++;
        end
        rst = 0; idle();
        tick();
        n_checks++; if (reg_write !== 1'b0) $display("FAIL mid_after: got %0h expected 0", reg_write); else n_pass++;
    endtask

    task automatic test_random();
        logic pend = 1'b0;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(63) == 0);
            alu_valid = ($urandom_range(2) == 0); alu_rd = 5'($urandom_range(7)); alu_wd = $urandom;
            if (!pend) begin
                md_valid = $urandom_range(1) == 1; md_rd = 5'($urandom_range(7)); md_wd = $urandom;
            end
            issue_valid = ($urandom_range(3) == 0); issue_rd = 5'($urandom_range(7));
            rs1 = 5'($urandom_range(7)); rs2 = 5'($urandom_range(7));
            #1;
            n_checks++; if (md_ready !== (mq.size() < int'(DEPTH))) $display("FAIL rnd_ready[%0d]: got %0h expected %0h", c, md_ready, mq.size() < int'(DEPTH)); else n_pass++;
            n_checks++; if (int'(md_count) != mq.size()) $display("FAIL rnd_count[%0d]: got %0d expected %0d", c, md_count, mq.size()); else n_pass++;
            n_checks++; if (rs1_busy !== mbusy[rs1] || rs2_busy !== mbusy[rs2])
                $display("FAIL rnd_busy[%0d]: got %0h%0h expected %0h%0h", c, rs1_busy, rs2_busy, mbusy[rs1], mbusy[rs2]); else n_pass++;
            pend = md_valid && !md_ready && !rst;
            tick();
            n_checks++; if (reg_write !== e_rw) $display("FAIL rnd_we[%0d]: got %0h expected %0h", c, reg_write, e_rw); else n_pass++;
            if (e_rw) begin
                n_checks++; if (rd !== e_rd || wd !== e_wd) $display("FAIL rnd_data[%0d]: got rd=%0d wd=%0h expected rd=%0d wd=%0h", c, rd, wd, e_rd, e_wd); else n_pass++;
            end
        end
        rst = 0; idle();
    endtask

    initial begin
        rst = 1; rs1 = 0; rs2 = 0; idle();
        test_reset();
        test_alu();
        test_contention();
        test_scoreboard();
        test_back_to_back();
        test_x0();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
